// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants, state type and helpers for the pipeline sequencing controller.
package pipe_ctrl_pkg;
    localparam int ADDR_W = 32;
    localparam int DEF_BOOT_CYCLES = 4;
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ALL  = 6'b111111;
    localparam logic [5:0] KEEP_FETCH = 6'b111100;
    typedef enum logic [1:0] {RUN, TRAP_SAVE, TRAP_JUMP, MRET_JUMP} state_t;
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(3);
    endfunction
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall/trap/redirect bundle between the sequencing controller and the pipeline.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;
    logic              stallreq_if;
    logic              stallreq_id;
    logic              stallreq_ex;
    logic              stallreq_mem;
    logic              branch_flag;
    logic [ADDR_W-1:0] branch_addr;
    logic              trap_req;
    logic [ADDR_W-1:0] trap_cause;
    logic [ADDR_W-1:0] trap_pc;
    logic              mret;
    logic [ADDR_W-1:0] mtvec;
    logic [ADDR_W-1:0] mepc;
    logic [5:0]        stalled;
    logic              flush;
    logic              redirect_flag;
    logic [ADDR_W-1:0] redirect_addr;
    logic              pc_change_en;
    logic              trap_ack;
    logic              csr_we;
    logic [ADDR_W-1:0] csr_mepc;
    logic [ADDR_W-1:0] csr_mcause;
    modport master (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  branch_flag, branch_addr, trap_req, trap_cause, trap_pc,
        input  mret, mtvec, mepc,
        output stalled, flush, redirect_flag, redirect_addr, pc_change_en,
        output trap_ack, csr_we, csr_mepc, csr_mcause
    );
    modport slave (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output branch_flag, branch_addr, trap_req, trap_cause, trap_pc,
        output mret, mtvec, mepc,
        input  stalled, flush, redirect_flag, redirect_addr, pc_change_en,
        input  trap_ack, csr_we, csr_mepc, csr_mcause
    );
endinterface

// File: rtl/pipe_ctrl_stall_encoder.sv
// pipe_ctrl_stall_encoder: priority-merges per-stage stall requests into the hold vector.
module pipe_ctrl_stall_encoder
    import pipe_ctrl_pkg::*;
(
    input  logic       req_if,
    input  logic       req_id,
    input  logic       req_ex,
    input  logic       req_mem,
    output logic [5:0] stalled
);
    // the oldest stalling stage freezes itself and everything younger
    assign stalled = req_mem ? STALL_MEM :
                     req_ex  ? STALL_EX  :
                     req_id  ? STALL_ID  :
                     req_if  ? STALL_IF  : STALL_NONE;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall merging, trap/mret/branch redirect arbitration and post-reset fetch gating.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES = DEF_BOOT_CYCLES
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.master bus
);
    localparam int CW = $clog2(BOOT_CYCLES + 1);
    state_t            state;
    logic [CW-1:0]     boot_cnt;
    logic [ADDR_W-1:0] mepc_q;
    logic [ADDR_W-1:0] mcause_q;
    logic [5:0]        enc;
    logic              boot_done;
    logic              run;
    logic              take_trap;
    logic              take_mret;
    logic              take_br;

    pipe_ctrl_stall_encoder u_enc (
        .req_if (bus.stallreq_if),
        .req_id (bus.stallreq_id),
        .req_ex (bus.stallreq_ex),
        .req_mem(bus.stallreq_mem),
        .stalled(enc)
    );

    // nothing is accepted until the boot counter saturates
    assign boot_done = boot_cnt == CW'(BOOT_CYCLES);
    assign run       = boot_done && state == RUN;
    assign take_trap = run && bus.trap_req && !bus.stallreq_mem;
    assign take_mret = run && bus.mret && !bus.trap_req && !bus.stallreq_mem;
    assign take_br   = run && bus.branch_flag && !take_trap && !take_mret;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            boot_cnt <= '0;
            mepc_q   <= '0;
            mcause_q <= '0;
        end else begin
            if (!boot_done) boot_cnt <= boot_cnt + CW'(1);
            if (take_trap) begin
                mepc_q   <= bus.trap_pc;
                mcause_q <= bus.trap_cause;
            end
            state <= state == RUN       ? (take_trap ? TRAP_SAVE : take_mret ? MRET_JUMP : RUN) :
                     state == TRAP_SAVE ? TRAP_JUMP : RUN;
        end
    end

    // a taken branch must still let PC/IF load the target even under a younger-stage stall
    assign bus.stalled       = state == TRAP_SAVE ? STALL_ALL :
                               run ? (take_br ? enc & KEEP_FETCH : enc) : STALL_NONE;
    assign bus.flush         = state != RUN || take_br;
    assign bus.redirect_flag = state == TRAP_JUMP || state == MRET_JUMP || take_br;
    assign bus.redirect_addr = state == TRAP_JUMP ? word_align(bus.mtvec) :
                               state == MRET_JUMP ? word_align(bus.mepc) :
                               take_br ? word_align(bus.branch_addr) : '0;
    assign bus.pc_change_en  = boot_done;
    assign bus.trap_ack      = take_trap;
    assign bus.csr_we        = state == TRAP_SAVE;
    assign bus.csr_mepc      = mepc_q;
    assign bus.csr_mcause    = mcause_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    typedef struct packed {
        logic [5:0]  stalled;
        logic        flush;
        logic        redirect;
        logic [31:0] addr;
        logic        pc_en;
        logic        ack;
        logic        we;
    } exp_t;

    logic clk = 0;
    logic rst = 1;
    int   n_cmp = 0;
    int   n_bad = 0;

    int          m_boot;
    int          m_pend[$];
    logic [31:0] m_mepc;
    logic [31:0] m_mcause;

    always #5 clk = ~clk;

    pipe_ctrl_if bus();

    pipe_ctrl #(.BOOT_CYCLES(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    task automatic idle();
        bus.stallreq_if  = 0;
        bus.stallreq_id  = 0;
        bus.stallreq_ex  = 0;
        bus.stallreq_mem = 0;
        bus.branch_flag  = 0;
        bus.branch_addr  = 0;
        bus.trap_req     = 0;
        bus.trap_cause   = 0;
        bus.trap_pc      = 0;
        bus.mret         = 0;
        bus.mtvec        = 0;
        bus.mepc         = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        idle();
        @(negedge clk);
        rst = 0;
    endtask

    // Reference: pending non-RUN cycles are a queue of actions (1 save, 2 trap jump, 3 mret jump).
    function automatic exp_t model();
        exp_t e;
        int   n;
        e = '0;
        e.pc_en = m_boot >= 4;
        if (!e.pc_en) return e;
        if (m_pend.size() != 0) begin
            e.flush = 1;
            if (m_pend[0] == 1) begin
                e.stalled = 6'h3f;
                e.we = 1;
            end else begin
                e.redirect = 1;
                e.addr = (m_pend[0] == 2 ? bus.mtvec : bus.mepc) & 32'hffff_fffc;
            end
            return e;
        end
        n = bus.stallreq_mem ? 5 : bus.stallreq_ex ? 4 : bus.stallreq_id ? 3 : bus.stallreq_if ? 2 : 0;
        e.stalled = 6'((1 << n) - 1);
        if (bus.trap_req && !bus.stallreq_mem) e.ack = 1;
        else if (bus.mret && !bus.stallreq_mem) e.ack = 0;
        else if (bus.branch_flag) begin
            e.redirect = 1;
            e.flush = 1;
            e.addr = bus.branch_addr & 32'hffff_fffc;
            e.stalled[1:0] = 2'b00;
        end
        return e;
    endfunction

    task automatic model_step(input exp_t e);
        if (m_pend.size() != 0) void'(m_pend.pop_front());
        else if (e.ack) begin
            m_pend.push_back(1);
            m_pend.push_back(2);
            m_mepc = bus.trap_pc;
            m_mcause = bus.trap_cause;
        end else if (e.pc_en && bus.mret && !bus.trap_req && !bus.stallreq_mem) m_pend.push_back(3);
        m_boot++;
    endtask

    task automatic test_reset();
        rst = 1;
        idle();
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (bus.stalled !== 6'b0) begin n_bad++; $display("FAIL reset_stalled: got %b want 000000", bus.stalled); end
        n_cmp++; if (bus.pc_change_en !== 1'b0) begin n_bad++; $display("FAIL reset_pc_en: got %b want 0", bus.pc_change_en); end
        n_cmp++; if (bus.redirect_flag !== 1'b0 || bus.flush !== 1'b0) begin n_bad++; $display("FAIL reset_redirect: got %b/%b want 0/0", bus.redirect_flag, bus.flush); end
        n_cmp++; if (bus.csr_mepc !== 32'h0 || bus.csr_mcause !== 32'h0) begin n_bad++; $display("FAIL reset_csr: got %h/%h want 0/0", bus.csr_mepc, bus.csr_mcause); end
    endtask

    task automatic test_boot();
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            n_cmp++; if (bus.pc_change_en !== (i == 4)) begin n_bad++; $display("FAIL boot_pc_en cyc%0d: got %b want %b", i, bus.pc_change_en, i == 4); end
            n_cmp++; if (bus.stalled !== 6'b0) begin n_bad++; $display("FAIL boot_stalled cyc%0d: got %b want 000000", i, bus.stalled); end
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        bus.stallreq_id = 1;
        bus.stallreq_mem = 1;
        #1;
        n_cmp++; if (bus.stalled !== 6'b011111) begin n_bad++; $display("FAIL stall_id_mem: got %b want 011111", bus.stalled); end
        @(negedge clk);
        idle();
        bus.stallreq_if = 1;
        #1;
        n_cmp++; if (bus.stalled !== 6'b000011) begin n_bad++; $display("FAIL stall_if: got %b want 000011", bus.stalled); end
        @(negedge clk);
        idle();
        bus.stallreq_ex = 1;
        bus.stallreq_id = 1;
        #1;
        n_cmp++; if (bus.stalled !== 6'b001111) begin n_bad++; $display("FAIL stall_ex: got %b want 001111", bus.stalled); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_branch();
        @(negedge clk);
        bus.branch_flag = 1;
        bus.branch_addr = 32'h0000_0206;
        bus.stallreq_ex = 1;
        #1;
        n_cmp++; if (bus.redirect_flag !== 1'b1 || bus.redirect_addr !== 32'h0000_0204) begin n_bad++; $display("FAIL branch_redirect: got %b %h want 1 00000204", bus.redirect_flag, bus.redirect_addr); end
        n_cmp++; if (bus.flush !== 1'b1) begin n_bad++; $display("FAIL branch_flush: got %b want 1", bus.flush); end
        n_cmp++; if (bus.stalled !== 6'b001100) begin n_bad++; $display("FAIL branch_stall_override: got %b want 001100", bus.stalled); end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (bus.redirect_flag !== 1'b0 || bus.flush !== 1'b0) begin n_bad++; $display("FAIL branch_release: got %b/%b want 0/0", bus.redirect_flag, bus.flush); end
    endtask

    task automatic test_trap();
        @(negedge clk);
        bus.trap_req = 1;
        bus.trap_cause = 32'hB;
        bus.trap_pc = 32'h80;
        bus.mtvec = 32'h103;
        #1;
        n_cmp++; if (bus.trap_ack !== 1'b1 || bus.csr_we !== 1'b0) begin n_bad++; $display("FAIL trap_ack: got ack %b we %b want 1 0", bus.trap_ack, bus.csr_we); end
        @(negedge clk);
        bus.trap_req = 0;
        #1;
        n_cmp++; if (bus.csr_we !== 1'b1 || bus.csr_mepc !== 32'h80 || bus.csr_mcause !== 32'hB) begin n_bad++; $display("FAIL trap_save: got we %b mepc %h cause %h want 1 80 b", bus.csr_we, bus.csr_mepc, bus.csr_mcause); end
        n_cmp++; if (bus.stalled !== 6'b111111 || bus.flush !== 1'b1 || bus.trap_ack !== 1'b0) begin n_bad++; $display("FAIL trap_save_ctl: got %b %b %b want 111111 1 0", bus.stalled, bus.flush, bus.trap_ack); end
        @(negedge clk);
        #1;
        n_cmp++; if (bus.redirect_flag !== 1'b1 || bus.redirect_addr !== 32'h100 || bus.flush !== 1'b1 || bus.stalled !== 6'b0) begin n_bad++; $display("FAIL trap_jump: got %b %h %b %b want 1 00000100 1 000000", bus.redirect_flag, bus.redirect_addr, bus.flush, bus.stalled); end
        @(negedge clk);
        #1;
        n_cmp++; if (bus.redirect_flag !== 1'b0 || bus.flush !== 1'b0 || bus.csr_we !== 1'b0) begin n_bad++; $display("FAIL trap_return_run: got %b %b %b want 0 0 0", bus.redirect_flag, bus.flush, bus.csr_we); end
    endtask

    task automatic test_trap_mem_stall();
        @(negedge clk);
        bus.trap_req = 1;
        bus.trap_cause = 32'h7;
        bus.trap_pc = 32'h90;
        bus.mtvec = 32'h200;
        bus.stallreq_mem = 1;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            n_cmp++; if (bus.trap_ack !== 1'b0 || bus.stalled !== 6'b011111) begin n_bad++; $display("FAIL trap_pending cyc%0d: got ack %b stall %b want 0 011111", i, bus.trap_ack, bus.stalled); end
        end
        @(negedge clk);
        bus.stallreq_mem = 0;
        bus.branch_flag = 1;
        bus.branch_addr = 32'h300;
        #1;
        n_cmp++; if (bus.trap_ack !== 1'b1 || bus.redirect_flag !== 1'b0 || bus.flush !== 1'b0) begin n_bad++; $display("FAIL trap_drop_branch: got ack %b redir %b flush %b want 1 0 0", bus.trap_ack, bus.redirect_flag, bus.flush); end
        @(negedge clk);
        idle();
        bus.mtvec = 32'h200;
        #1;
        n_cmp++; if (bus.csr_we !== 1'b1 || bus.csr_mepc !== 32'h90 || bus.csr_mcause !== 32'h7) begin n_bad++; $display("FAIL trap2_save: got we %b mepc %h cause %h want 1 90 7", bus.csr_we, bus.csr_mepc, bus.csr_mcause); end
        @(negedge clk);
        #1;
        n_cmp++; if (bus.redirect_flag !== 1'b1 || bus.redirect_addr !== 32'h200) begin n_bad++; $display("FAIL trap2_jump: got %b %h want 1 00000200", bus.redirect_flag, bus.redirect_addr); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_mret();
        @(negedge clk);
        bus.mret = 1;
        bus.mepc = 32'h84;
        #1;
        n_cmp++; if (bus.redirect_flag !== 1'b0) begin n_bad++; $display("FAIL mret_entry: got %b want 0", bus.redirect_flag); end
        @(negedge clk);
        bus.mret = 0;
        #1;
        n_cmp++; if (bus.redirect_flag !== 1'b1 || bus.redirect_addr !== 32'h84 || bus.flush !== 1'b1) begin n_bad++; $display("FAIL mret_jump: got %b %h %b want 1 00000084 1", bus.redirect_flag, bus.redirect_addr, bus.flush); end
        @(negedge clk);
        #1;
        n_cmp++; if (bus.redirect_flag !== 1'b0 || bus.flush !== 1'b0) begin n_bad++; $display("FAIL mret_return: got %b %b want 0 0", bus.redirect_flag, bus.flush); end
    endtask

    task automatic test_reset_in_trap();
        @(negedge clk);
        idle();
        bus.trap_req = 1;
        bus.trap_cause = 32'h3;
        bus.trap_pc = 32'h44;
        #1;
        n_cmp++; if (bus.trap_ack !== 1'b1) begin n_bad++; $display("FAIL rst_trap_ack: got %b want 1", bus.trap_ack); end
        @(negedge clk);
        bus.trap_req = 0;
        #1;
        n_cmp++; if (bus.csr_we !== 1'b1) begin n_bad++; $display("FAIL rst_trap_save: got %b want 1", bus.csr_we); end
        rst = 1;
        #1;
        n_cmp++; if (bus.csr_we !== 1'b0 || bus.stalled !== 6'b0 || bus.flush !== 1'b0 || bus.pc_change_en !== 1'b0) begin n_bad++; $display("FAIL rst_async_outputs: got we %b stall %b flush %b en %b want 0 000000 0 0", bus.csr_we, bus.stalled, bus.flush, bus.pc_change_en); end
        n_cmp++; if (bus.csr_mepc !== 32'h0 || bus.csr_mcause !== 32'h0) begin n_bad++; $display("FAIL rst_async_csr: got %h %h want 0 0", bus.csr_mepc, bus.csr_mcause); end
        @(negedge clk);
        rst = 0;
        bus.branch_flag = 1;
        bus.branch_addr = 32'h41;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            n_cmp++; if (bus.redirect_flag !== (i == 4) || bus.pc_change_en !== (i == 4)) begin n_bad++; $display("FAIL reboot cyc%0d: got redir %b en %b want %b %b", i, bus.redirect_flag, bus.pc_change_en, i == 4, i == 4); end
        end
        n_cmp++; if (bus.redirect_addr !== 32'h40) begin n_bad++; $display("FAIL reboot_branch_addr: got %h want 00000040", bus.redirect_addr); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_random();
        exp_t        e;
        logic        hold = 0;
        logic [31:0] r_cause = 0;
        logic [31:0] r_pc = 0;
        do_reset();
        m_boot = 1;
        m_pend.delete();
        m_mepc = 0;
        m_mcause = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!hold && $urandom_range(0, 11) == 0) begin
                hold = 1;
                r_cause = $urandom;
                r_pc = $urandom;
            end
            bus.trap_req     = hold;
            bus.trap_cause   = r_cause;
            bus.trap_pc      = r_pc;
            bus.stallreq_if  = $urandom_range(0, 3) == 0;
            bus.stallreq_id  = $urandom_range(0, 3) == 0;
            bus.stallreq_ex  = $urandom_range(0, 3) == 0;
            bus.stallreq_mem = $urandom_range(0, 3) == 0;
            bus.branch_flag  = $urandom_range(0, 2) == 0;
            bus.branch_addr  = $urandom;
            bus.mret         = $urandom_range(0, 7) == 0;
            bus.mtvec        = $urandom;
            bus.mepc         = $urandom;
            #1;
            e = model();
            n_cmp++; if (bus.stalled !== e.stalled) begin n_bad++; $display("FAIL rnd_stalled cyc%0d: got %b want %b", i, bus.stalled, e.stalled); end
            n_cmp++; if (bus.flush !== e.flush) begin n_bad++; $display("FAIL rnd_flush cyc%0d: got %b want %b", i, bus.flush, e.flush); end
            n_cmp++; if (bus.redirect_flag !== e.redirect) begin n_bad++; $display("FAIL rnd_redirect cyc%0d: got %b want %b", i, bus.redirect_flag, e.redirect); end
            if (e.redirect) begin
                n_cmp++; if (bus.redirect_addr !== e.addr) begin n_bad++; $display("FAIL rnd_addr cyc%0d: got %h want %h", i, bus.redirect_addr, e.addr); end
            end
            n_cmp++; if (bus.pc_change_en !== e.pc_en) begin n_bad++; $display("FAIL rnd_pc_en cyc%0d: got %b want %b", i, bus.pc_change_en, e.pc_en); end
            n_cmp++; if (bus.trap_ack !== e.ack) begin n_bad++; $display("FAIL rnd_ack cyc%0d: got %b want %b", i, bus.trap_ack, e.ack); end
            n_cmp++; if (bus.csr_we !== e.we) begin n_bad++; $display("FAIL rnd_we cyc%0d: got %b want %b", i, bus.csr_we, e.we); end
            n_cmp++; if (bus.csr_mepc !== m_mepc || bus.csr_mcause !== m_mcause) begin n_bad++; $display("FAIL rnd_csr cyc%0d: got %h %h want %h %h", i, bus.csr_mepc, bus.csr_mcause, m_mepc, m_mcause); end
            if (e.ack) hold = 0;
            model_step(e);
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_boot();
        test_stall();
        test_branch();
        test_trap();
        test_trap_mem_stall();
        test_mret();
        test_reset_in_trap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
